// File: rtl/cq_squash.sv
// Completion queue between execute and complete with ROB-age selective squash and full flush.
// Define CQ_BYPASS_EN to let accepted results leave in the same cycle when the queue is empty.
module cq_squash #(
   parameter int unsigned C_WIDTH  = 2,
   parameter int unsigned E_WIDTH  = 4,
   parameter int unsigned SIZE     = 32,
   parameter int unsigned ROB_SIZE = 32,
   parameter int unsigned PREG_W   = 6,
   parameter int unsigned XLEN     = 32,
   localparam int unsigned RI      = $clog2(ROB_SIZE),
   localparam int unsigned IW      = $clog2(SIZE),
   localparam int unsigned EX_W    = 1 + PREG_W + RI + XLEN,
   localparam int unsigned CP_W    = 1 + PREG_W + RI
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [E_WIDTH-1:0][EX_W-1:0]       execute,
   output logic [E_WIDTH-1:0]                 stall,
   input  logic                               complete_stall,
   input  logic                               squash_valid,
   input  logic [RI-1:0]                      squash_rob_index,
   input  logic [RI-1:0]                      rob_head,
   output logic [C_WIDTH-1:0][CP_W-1:0]       complete,
   output logic [C_WIDTH-1:0][PREG_W-1:0]     reg_file_write_tag,
   output logic [C_WIDTH-1:0][XLEN-1:0]       reg_file_write_value,
   output logic [IW:0]                        occupancy
);

   localparam int unsigned CNT_W   = IW + 1;
   localparam int unsigned CW      = (C_WIDTH > 1) ? $clog2(C_WIDTH) : 1;
   localparam int unsigned OUT_W   = CW + 1;
   localparam int unsigned V_B     = EX_W - 1;
   localparam int unsigned TAG_LSB = RI + XLEN;
   localparam int unsigned ROB_LSB = XLEN;

   logic [SIZE-1:0]   valid_q;
   logic [PREG_W-1:0] tag_q [SIZE];
   logic [RI-1:0]     rob_q [SIZE];
   logic [XLEN-1:0]   val_q [SIZE];
   logic [IW-1:0]     head_q, tail_q;
   logic [CNT_W-1:0]  count_q;

   logic [RI-1:0]     br_age;
   logic [IW-1:0]     rd_idx   [C_WIDTH];
   logic [E_WIDTH-1:0] enq_en;
   logic [IW-1:0]     enq_slot [E_WIDTH];
   logic [CNT_W-1:0]  pop_n, enq_n, acc_n;
   logic [OUT_W-1:0]  out_n;

   // Age is measured from the ROB head so comparisons survive ROB index wrap-around.
   function automatic logic is_younger(input logic [RI-1:0] rob, input logic [RI-1:0] head,
                                       input logic [RI-1:0] br, input logic sq);
      logic [RI-1:0] age;
      age = rob - head;
      return sq && (age > br);
   endfunction

   assign br_age    = squash_rob_index - rob_head;
   assign occupancy = count_q;

`ifdef CQ_BYPASS_EN
   logic byp_ok;
   assign byp_ok = (count_q == '0) && !complete_stall;
`endif

   always_comb begin
      for (int unsigned k = 0; k < C_WIDTH; k++) begin
         rd_idx[k] = head_q + IW'(k);
      end
   end

   always_comb begin
      stall                = '0;
      complete             = '0;
      reg_file_write_tag   = '0;
      reg_file_write_value = '0;
      enq_en               = '0;
      pop_n                = '0;
      enq_n                = '0;
      acc_n                = '0;
      out_n                = '0;
      for (int unsigned i = 0; i < E_WIDTH; i++) begin
         enq_slot[i] = '0;
      end
      if (!flush) begin
         // Squashed entries still consume a drain slot but produce no output lane.
         for (int unsigned k = 0; k < C_WIDTH; k++) begin
            if (CNT_W'(k) < count_q) begin
               if (valid_q[rd_idx[k]] &&
                   !is_younger(rob_q[rd_idx[k]], rob_head, br_age, squash_valid)) begin
                  complete[out_n[CW-1:0]] = {!complete_stall, tag_q[rd_idx[k]], rob_q[rd_idx[k]]};
                  if (!complete_stall) begin
                     reg_file_write_tag[out_n[CW-1:0]]   = tag_q[rd_idx[k]];
                     reg_file_write_value[out_n[CW-1:0]] = val_q[rd_idx[k]];
                  end
                  out_n = out_n + OUT_W'(1);
               end
               if (!complete_stall) begin
                  pop_n = pop_n + CNT_W'(1);
               end
            end
         end
         for (int unsigned i = 0; i < E_WIDTH; i++) begin
            if (execute[i][V_B] &&
                !is_younger(execute[i][ROB_LSB +: RI], rob_head, br_age, squash_valid)) begin
               if ((count_q + acc_n) < CNT_W'(SIZE)) begin
                  acc_n = acc_n + CNT_W'(1);
`ifdef CQ_BYPASS_EN
                  if (byp_ok && (out_n < OUT_W'(C_WIDTH))) begin
                     complete[out_n[CW-1:0]] = {1'b1, execute[i][TAG_LSB +: PREG_W],
                                                execute[i][ROB_LSB +: RI]};
                     reg_file_write_tag[out_n[CW-1:0]]   = execute[i][TAG_LSB +: PREG_W];
                     reg_file_write_value[out_n[CW-1:0]] = execute[i][XLEN-1:0];
                     out_n = out_n + OUT_W'(1);
                  end else
`endif
                  begin
                     enq_en[i]   = 1'b1;
                     enq_slot[i] = tail_q + enq_n[IW-1:0];
                     enq_n       = enq_n + CNT_W'(1);
                  end
               end else begin
                  stall[i] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         valid_q <= '0;
      end else begin
         head_q  <= head_q + pop_n[IW-1:0];
         tail_q  <= tail_q + enq_n[IW-1:0];
         count_q <= count_q + enq_n - pop_n;
         for (int unsigned e = 0; e < SIZE; e++) begin
            if (is_younger(rob_q[e], rob_head, br_age, squash_valid)) begin
               valid_q[e] <= 1'b0;
            end
         end
         for (int unsigned i = 0; i < E_WIDTH; i++) begin
            if (enq_en[i]) begin
               valid_q[enq_slot[i]] <= 1'b1;
               tag_q[enq_slot[i]]   <= execute[i][TAG_LSB +: PREG_W];
               rob_q[enq_slot[i]]   <= execute[i][ROB_LSB +: RI];
               val_q[enq_slot[i]]   <= execute[i][XLEN-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_cq_squash.sv
// Bench for cq_squash: directed vector table, hand sequences for squash/wrap/flush, and
// randomized traffic checked against a queue-based reference model.
module tb_cq_squash;
   localparam int C = 2, E = 4, SZ = 8, ROBS = 32, PW = 6, XL = 32, RI = 5;
   localparam int EXW = 1 + PW + RI + XL, CPW = 1 + PW + RI;

   logic clock = 1'b0;
   logic reset, flush, complete_stall, squash_valid;
   logic [E-1:0][EXW-1:0] execute;
   logic [E-1:0] stall;
   logic [RI-1:0] squash_rob_index, rob_head;
   logic [C-1:0][CPW-1:0] complete;
   logic [C-1:0][PW-1:0] wtag;
   logic [C-1:0][XL-1:0] wval;
   logic [3:0] occupancy;

   cq_squash #(.C_WIDTH(C), .E_WIDTH(E), .SIZE(SZ), .ROB_SIZE(ROBS), .PREG_W(PW), .XLEN(XL)) dut (
      .clock(clock), .reset(reset), .flush(flush), .execute(execute), .stall(stall),
      .complete_stall(complete_stall), .squash_valid(squash_valid),
      .squash_rob_index(squash_rob_index), .rob_head(rob_head), .complete(complete),
      .reg_file_write_tag(wtag), .reg_file_write_value(wval), .occupancy(occupancy));

   always #5 clock = ~clock;

   bit        in_v   [E];
   bit [4:0]  in_rob [E];
   bit [5:0]  in_tag [E];
   bit [31:0] in_val [E];

   int unsigned n_vec = 0, n_bad = 0;

   typedef struct {bit live; bit [4:0] rob; bit [5:0] tag; bit [31:0] val;} ent_t;
   ent_t mq[$];

   typedef struct {
      bit [3:0] ev; bit [3:0][4:0] rob; bit cs; bit sqv; bit [4:0] sqr; bit fl;
      bit [3:0] x_occ; bit [1:0] x_cv; bit [4:0] x_r0; bit [4:0] x_r1; bit [3:0] x_st;
   } row_t;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit young(bit [4:0] r, bit [4:0] br);
      bit [4:0] a;
      a = r - rob_head;
      return squash_valid && (a > br);
   endfunction

   task automatic drive();
      for (int i = 0; i < E; i++) execute[i] = {in_v[i], in_tag[i], in_rob[i], in_val[i]};
   endtask

   // Reference: entries held in age order; outputs derived from the first C, then updated.
   task automatic model_check();
      bit [CPW-1:0] xc [C];
      bit [PW-1:0] xt [C];
      bit [XL-1:0] xv [C];
      bit [E-1:0] xs;
      bit [4:0] br;
      int o, n, acc, pops;
      ent_t nq[$];
      xs = '0; o = 0; acc = 0;
      for (int c = 0; c < C; c++) begin xc[c] = '0; xt[c] = '0; xv[c] = '0; end
      n = mq.size();
      nq = mq;
      if (!flush) begin
         br = squash_rob_index - rob_head;
         for (int k = 0; k < C && k < n; k++) begin
            if (mq[k].live && !young(mq[k].rob, br)) begin
               xc[o] = {!complete_stall, mq[k].tag, mq[k].rob};
               if (!complete_stall) begin xt[o] = mq[k].tag; xv[o] = mq[k].val; end
               o++;
            end
         end
         pops = complete_stall ? 0 : ((n < C) ? n : C);
         for (int k = 0; k < nq.size(); k++) if (young(nq[k].rob, br)) nq[k].live = 1'b0;
         for (int k = 0; k < pops; k++) void'(nq.pop_front());
         for (int i = 0; i < E; i++) begin
            if (in_v[i] && !young(in_rob[i], br)) begin
               if (n + acc < SZ) begin
                  acc++;
`ifdef CQ_BYPASS_EN
                  if (n == 0 && !complete_stall && o < C) begin
                     xc[o] = {1'b1, in_tag[i], in_rob[i]}; xt[o] = in_tag[i]; xv[o] = in_val[i];
                     o++;
                  end else
`endif
                  nq.push_back('{1'b1, in_rob[i], in_tag[i], in_val[i]});
               end else begin
                  xs[i] = 1'b1;
               end
            end
         end
      end else begin
         nq = {};
      end
      for (int c = 0; c < C; c++) begin
         if (complete_stall && !flush) check("complete_valid", complete[c][CPW-1], xc[c][CPW-1]);
         else check("complete", complete[c], xc[c]);
         check("write_tag", wtag[c], xt[c]);
         check("write_value", wval[c], xv[c]);
      end
      check("stall", stall, xs);
      check("occupancy", occupancy, n);
      mq = nq;
   endtask

   task automatic tick();
      @(negedge clock);
      model_check();
      @(posedge clock); #1;
   endtask

   function automatic bit [3:0][4:0] sq(bit [4:0] base);
      bit [3:0][4:0] r;
      for (int i = 0; i < 4; i++) r[i] = base + 5'(i);
      return r;
   endfunction

   function automatic row_t mk(bit [3:0] ev, bit [3:0][4:0] rob, bit cs, bit sqv, bit [4:0] sqr,
                               bit fl, bit [3:0] xocc, bit [1:0] xcv, bit [4:0] xr0,
                               bit [4:0] xr1, bit [3:0] xst);
      row_t r;
      r.ev = ev; r.rob = rob; r.cs = cs; r.sqv = sqv; r.sqr = sqr; r.fl = fl;
      r.x_occ = xocc; r.x_cv = xcv; r.x_r0 = xr0; r.x_r1 = xr1; r.x_st = xst;
      return r;
   endfunction

   task automatic run_row(row_t r);
      for (int i = 0; i < E; i++) begin
         in_v[i] = r.ev[i]; in_rob[i] = r.rob[i];
         in_tag[i] = 6'(r.rob[i]) + 6'd1; in_val[i] = 32'hC0DE_0000 | 32'(r.rob[i]);
      end
      complete_stall = r.cs; squash_valid = r.sqv; squash_rob_index = r.sqr;
      rob_head = '0; flush = r.fl;
      drive();
      @(negedge clock);
      check("row_occupancy", occupancy, r.x_occ);
      check("row_valid", {complete[1][CPW-1], complete[0][CPW-1]}, r.x_cv);
      if (r.x_cv[0]) check("row_rob0", complete[0][RI-1:0], r.x_r0);
      if (r.x_cv[1]) check("row_rob1", complete[1][RI-1:0], r.x_r1);
      check("row_stall", stall, r.x_st);
      model_check();
      @(posedge clock); #1;
   endtask

   row_t rows [26];

   initial begin
      int exp_next, pend_base, cyc;
      rows[0]  = mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[1]  = mk(4'hF, sq(3),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[2]  = mk(4'h0, sq(0),  0, 0, 0, 0, 4, 2'b11, 3, 4, 4'h0);
      rows[3]  = mk(4'h0, sq(0),  0, 0, 0, 0, 2, 2'b11, 5, 6, 4'h0);
      rows[4]  = mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[5]  = mk(4'h3, sq(7),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[6]  = mk(4'h0, sq(0),  1, 0, 0, 0, 2, 2'b00, 0, 0, 4'h0);
      rows[7]  = mk(4'h0, sq(0),  1, 0, 0, 0, 2, 2'b00, 0, 0, 4'h0);
      rows[8]  = mk(4'h0, sq(0),  1, 0, 0, 0, 2, 2'b00, 0, 0, 4'h0);
      rows[9]  = mk(4'h0, sq(0),  0, 0, 0, 0, 2, 2'b11, 7, 8, 4'h0);
      rows[10] = mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[11] = mk(4'hF, sq(9),  1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[12] = mk(4'h7, sq(13), 1, 0, 0, 0, 4, 2'b00, 0, 0, 4'h0);
      rows[13] = mk(4'h7, sq(16), 0, 0, 0, 0, 7, 2'b11, 9, 10, 4'h6);
      rows[14] = mk(4'h3, sq(17), 0, 0, 0, 0, 6, 2'b11, 11, 12, 4'h0);
      rows[15] = mk(4'h0, sq(0),  0, 0, 0, 0, 6, 2'b11, 13, 14, 4'h0);
      rows[16] = mk(4'h0, sq(0),  0, 0, 0, 0, 4, 2'b11, 15, 16, 4'h0);
      rows[17] = mk(4'h0, sq(0),  0, 0, 0, 0, 2, 2'b11, 17, 18, 4'h0);
      rows[18] = mk(4'hF, sq(19), 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);
      rows[19] = mk(4'hF, sq(23), 1, 0, 0, 0, 4, 2'b00, 0, 0, 4'h0);
      rows[20] = mk(4'h1, sq(27), 0, 0, 0, 0, 8, 2'b11, 19, 20, 4'h1);
      rows[21] = mk(4'h1, sq(27), 0, 0, 0, 0, 6, 2'b11, 21, 22, 4'h0);
      rows[22] = mk(4'h0, sq(0),  0, 0, 0, 0, 5, 2'b11, 23, 24, 4'h0);
      rows[23] = mk(4'h0, sq(0),  0, 0, 0, 0, 3, 2'b11, 25, 26, 4'h0);
      rows[24] = mk(4'h0, sq(0),  0, 0, 0, 0, 1, 2'b01, 27, 0, 4'h0);
      rows[25] = mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0);

      reset = 1'b1; flush = 1'b0; complete_stall = 1'b0; squash_valid = 1'b0;
      squash_rob_index = '0; rob_head = '0;
      for (int i = 0; i < E; i++) begin in_v[i] = 0; in_rob[i] = 0; in_tag[i] = 0; in_val[i] = 0; end
      drive();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      mq = {};

      for (int r = 0; r < 26; r++) run_row(rows[r]);

      // Selective squash: 5 and 7 are younger than branch 4; incoming 6 is dropped.
      run_row(mk(4'h7, {5'd0, 5'd7, 5'd5, 5'd2}, 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h1, {5'd0, 5'd0, 5'd0, 5'd6}, 1, 1, 4, 0, 3, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h0, sq(0), 0, 0, 0, 0, 3, 2'b01, 2, 0, 4'h0));
      run_row(mk(4'h0, sq(0), 0, 0, 0, 0, 1, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h0, sq(0), 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));

      // Twelve results through an eight-entry queue, FUs re-presenting stalled lanes.
      exp_next = 0; pend_base = 0; cyc = 0;
      while (exp_next < 12 && cyc < 40) begin
         int npres, accepted;
         npres = (12 - pend_base < E) ? 12 - pend_base : E;
         for (int i = 0; i < E; i++) begin
            in_v[i] = (i < npres); in_rob[i] = 5'(pend_base + i);
            in_tag[i] = 6'(pend_base + i) + 6'd1; in_val[i] = 32'hBEEF_0000 + 32'(pend_base + i);
         end
         complete_stall = 0; squash_valid = 0; flush = 0; rob_head = '0;
         drive();
         @(negedge clock);
         for (int c = 0; c < C; c++) begin
            if (complete[c][CPW-1]) begin
               check("wrap_order", complete[c][RI-1:0], exp_next);
               exp_next++;
            end
         end
         accepted = 0;
         for (int i = 0; i < npres; i++) if (!stall[i]) accepted++;
         model_check();
         @(posedge clock); #1;
         pend_base += accepted;
         cyc++;
      end
      check("wrap_done", exp_next, 12);

      // Flush with five held entries and live inputs present.
      run_row(mk(4'hF, sq(20), 1, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h1, sq(24), 1, 0, 0, 0, 4, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'hF, sq(25), 1, 1, 0, 1, 5, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h1, sq(9),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));
      run_row(mk(4'h0, sq(0),  0, 0, 0, 0, 1, 2'b01, 9, 0, 4'h0));
      run_row(mk(4'h0, sq(0),  0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0));

      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < E; i++) begin
            in_v[i] = 1'($urandom_range(0, 1)); in_rob[i] = 5'($urandom);
            in_tag[i] = 6'($urandom); in_val[i] = $urandom;
         end
         complete_stall   = ($urandom_range(0, 3) == 0);
         squash_valid     = ($urandom_range(0, 9) == 0);
         flush            = ($urandom_range(0, 29) == 0);
         squash_rob_index = 5'($urandom);
         rob_head         = 5'($urandom);
         drive();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
